// File: rtl/psubsb_serial_pkg.sv
// Shared types and constants for the nibble-serial saturating subtractor.
package psubsb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } psub_state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 4;

    localparam logic [LANE_W-1:0] SAT_MAX = 4'h7;
    localparam logic [LANE_W-1:0] SAT_MIN = 4'h8;

endpackage

// File: rtl/psubsb_serial_if.sv
// Start/busy/done operand and result bundle between the requester and psubsb_serial.
interface psubsb_serial_if
    import psubsb_pkg::*;
#(
    parameter int LANES = 4
);

    logic                      start;
    logic [LANES*LANE_W-1:0]   a;
    logic [LANES*LANE_W-1:0]   b;
    logic [LANES*LANE_W-1:0]   diff;
    logic [LANES-1:0]          sat;
    logic                      busy;
    logic                      done;

    modport master (
        output start, a, b,
        input  diff, sat, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, sat, busy, done
    );

endinterface

// File: rtl/psubsb_serial_nibble_sub_sat.sv
// Combinational signed 4-bit subtract a - b, clamped to the nibble range [-8, +7].
module nibble_sub_sat
    import psubsb_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] d,
    output logic              sat
);

    localparam logic signed [LANE_W:0] D_MAX = {SAT_MAX[LANE_W-1], SAT_MAX};
    localparam logic signed [LANE_W:0] D_MIN = {SAT_MIN[LANE_W-1], SAT_MIN};

    // One guard bit is enough: the widest difference, 7 - (-8), fits in 5 bits.
    logic signed [LANE_W:0] d_full;

    assign d_full = $signed({a[LANE_W-1], a}) - $signed({b[LANE_W-1], b});

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        d   = d_full[LANE_W-1:0];
        sat = 1'b0;
        if (d_full > D_MAX) begin
            d   = SAT_MAX;
            sat = 1'b1;
        end else if (d_full < D_MIN) begin
            d   = SAT_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/psubsb_serial.sv
// Multi-cycle saturating nibble subtractor: one lane per clock through a shared
// nibble_sub_sat, with a start/busy/done handshake.
module psubsb_serial
    import psubsb_pkg::*;
#(
    parameter int LANES = psubsb_pkg::LANES
)(
    input  logic          clk,
    input  logic          rst,
    psubsb_serial_if.slave bus
);

    localparam int W  = LANES * LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    psub_state_t      state_q, state_d;
    logic [CW-1:0]    lane_q,  lane_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     diff_q,  diff_d;
    logic [LANES-1:0] sat_q,   sat_d;

    logic [LANE_W-1:0] a_lane, b_lane, d_lane;
    logic              sat_lane;

    assign a_lane = a_q[lane_q*LANE_W +: LANE_W];
    assign b_lane = b_q[lane_q*LANE_W +: LANE_W];

    nibble_sub_sat u_lane (
        .a   (a_lane),
        .b   (b_lane),
        .d   (d_lane),
        .sat (sat_lane)
    );

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = CALC;
                    lane_d  = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    diff_d  = '0;
                    sat_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Only the addressed lane is written; start is ignored here.
                diff_d[lane_q*LANE_W +: LANE_W] = d_lane;
                sat_d[lane_q]                   = sat_lane;
                lane_d                          = lane_q + CW'(1);
                if (lane_q == CW'(LANES - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            sat_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            lane_q  <= lane_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.sat  = sat_q;
    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_psubsb_serial.sv
// Directed and randomized checks of psubsb_serial against a per-lane clamp model.
module tb_psubsb_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    psubsb_serial_if #(.LANES(4)) bus ();

    psubsb_serial #(.LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {sat[3:0], diff[15:0]} from signed nibble arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        logic [3:0]  s;
        int sa, sb, r;
        d = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            sa = int'(a[4*i +: 4]);
            sb = int'(b[4*i +: 4]);
            if (sa > 7) sa -= 16;
            if (sb > 7) sb -= 16;
            r = sa - sb;
            if (r > 7) begin
                r = 7;
                s[i] = 1'b1;
            end else if (r < -8) begin
                r = -8;
                s[i] = 1'b1;
            end
            if (r < 0) r += 16;
            d[4*i +: 4] = 4'(r);
        end
        return {s, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int exp_n, input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic check_result(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [19:0] e;
        e = model(a, b);
        check({tag, "_diff"}, 32'(bus.diff), 32'(e[15:0]));
        check({tag, "_sat"},  32'(bus.sat),  32'(e[19:16]));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
            check("done_width",     32'(bus.done & done_prev), 32'd0);
            done_prev <= bus.done;
        end
    end

    initial begin
        logic [15:0] ra, rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        tick();
        tick();
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_sat",  32'(bus.sat),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        tick();

        // Vector 1: only lane 3 clamps high
        bus.a = 16'h760A; bus.b = 16'hA6CD; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("v1_busy", 32'(bus.busy), 32'd1);
        wait_done(4, "v1_latency");
        check("v1_diff_const", 32'(bus.diff), 32'h704D);
        check("v1_sat_const",  32'(bus.sat),  32'h8);
        check_result(16'h760A, 16'hA6CD, "v1");
        tick();
        check("v1_done_drop", 32'(bus.done), 32'd0);

        // Vector 2: equal operands, then back-to-back via start held in DONE
        bus.a = 16'h1234; bus.b = 16'h1234; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(4, "v2_latency");
        check("v2_diff", 32'(bus.diff), 32'h0000);
        check("v2_sat",  32'(bus.sat),  32'h0);
        bus.a = 16'h8F70; bus.b = 16'h7118; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done", 32'(bus.done), 32'd0);
        check("b2b_diff_cleared", 32'(bus.diff), 32'd0);
        wait_done(4, "b2b_latency");
        check("v3_diff", 32'(bus.diff), 32'h8E67);
        check("v3_sat",  32'(bus.sat),  32'h9);
        tick();

        // Start and operand changes during CALC are ignored
        bus.a = 16'h760A; bus.b = 16'hA6CD; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a = 16'h8F70; bus.b = 16'h7118; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(2, "midcalc_latency");
        check_result(16'h760A, 16'hA6CD, "midcalc");
        tick();
        check("midcalc_one_done", 32'(bus.done), 32'd0);
        check("midcalc_no_restart", 32'(bus.busy), 32'd0);

        // Asynchronous reset at E2
        bus.a = 16'h760A; bus.b = 16'hA6CD; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("arst_diff", 32'(bus.diff), 32'd0);
        check("arst_sat",  32'(bus.sat),  32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        bus.a = 16'h8F70; bus.b = 16'h7118; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(4, "post_rst_latency");
        check_result(16'h8F70, 16'h7118, "post_rst");
        tick();

        // Random sweep, alternating idle gaps and back-to-back accepts
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            bus.a = ra; bus.b = rb; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            wait_done(4, "rnd_latency");
            check_result(ra, rb, "rnd");
            if ($urandom_range(1, 0) == 0) tick();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psubsb_serial.md
# psubsb_serial

Sequential nibble-serial saturating subtractor, the inverse of the team's parallel saturating nibble adder. It computes four independent 4-bit signed differences `a - b`, each clamped to [-8, +7], one lane per clock. It sits beside the ALU as a multi-cycle execute unit and uses a start/busy/done handshake.

## Interface
Parameters:
- `LANES`, default 4: number of 4-bit lanes; the operand width is `4*LANES`. The design is verified only at 4.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge only in IDLE or DONE.
- `a`  in  16  minuend; four signed nibbles, lane 0 = `[3:0]`.
- `b`  in  16  subtrahend; same layout.
- `diff`  out  16  registered result; holds until the next accepted start.
- `sat`  out  4  registered per-lane saturation flags; bit i set when lane i clamped.
- `busy`  out  1  high in CALC.
- `done`  out  1  one-cycle pulse; `diff` and `sat` are valid with it and afterwards.

## Operation
- Reset value of every output is 0. Internal registers are cleared, the lane counter is 0, and the state is IDLE.
- States: IDLE, CALC, DONE.
  - IDLE: `start` goes to CALC and latches `a` and `b` into operand registers. It also clears `diff` and `sat`.
  - CALC: one lane per cycle, starting with lane 0. The lane counter increments each cycle. After lane 3 is written, the state goes to DONE.
  - DONE: `done`=1. Without `start`, the state goes to IDLE. With `start`, the state goes straight to CALC and latches new operands (back-to-back accept).
- `start` in CALC is ignored. Operand changes after capture have no effect.
- Lane arithmetic:
  - Sign-extend both nibbles to 5 bits and compute d = a_i - b_i.
  - d > 7 gives 4'h7 with sat_i=1. d < -8 gives 4'h8 with sat_i=1. Otherwise the result is d[3:0] with sat_i=0.
- Lanes never carry into each other.
- Asynchronous `rst` in any state, including mid-CALC, immediately zeroes all outputs and returns to IDLE. No partial result is ever flagged `done`.

## Timing
- Edge E0: start accepted, operands captured, `busy`=1 after E0.
- Edges E1..E4: lanes 0..3 written into `diff`/`sat`. Partial results are visible but not valid.
- After E4: `busy`=0 and `done`=1 for exactly one cycle. After E5, `done`=0 unless a new start was accepted at E5, in which case `busy`=1.
- Latency from start sample to `done` high is 4 cycles. Throughput is one operation per 5 cycles back-to-back.
- `busy` and `done` are never high together. Both are registered decodes of the state.

## Structure
- Package `psubsb_pkg` holds:
  - state enum `psub_state_t` {IDLE, CALC, DONE};
  - `LANES` = 4, `LANE_W` = 4;
  - `SAT_MAX` = 4'h7, `SAT_MIN` = 4'h8.
- Sub-module `nibble_sub_sat` is combinational. Inputs `a[3:0]`, `b[3:0]`; outputs `d[3:0]`, `sat`. It is instantiated once and fed by a lane mux driven by the counter.
- The top level contains the FSM, the 2-bit lane counter, the operand registers, and the result registers with per-lane write enable.

## Test plan
- Reset, then a=0x760A, b=0xA6CD, start -> 4 cycles later done=1, diff=0x704D, sat=4'b1000.
- a=0x8F70, b=0x7118 -> diff=0x8E67, sat=4'b1001 (lane 3 clamps to -8, lane 0 clamps to +7).
- a=b=0x1234 -> diff=0x0000, sat=0. Then hold start high through the DONE cycle -> second op accepted immediately, busy=1 the next cycle, done pulses again 5 cycles after the first.
- Pulse start, then change a/b and pulse start again mid-CALC -> result matches the original operands, and only one done pulse occurs.
- Assert rst at E2 during CALC -> diff=0, sat=0, busy=0, done=0 immediately. After release, a new op completes correctly.
- Random sweep of 1000 operand pairs checked against a per-lane clamp model. Check that done is never high with busy, and that done is exactly one cycle wide.
